// File: rtl/stall_sched.sv
// Pipeline stall/flush scheduler: memory-wait stalls, load-use bubbles and branch redirects
// with a held redirect while fetch is busy, plus a sticky data-memory watchdog and event counters.
module stall_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken_EXB,
    input  logic [63:0] branch_target_EXB,
    input  logic        load_use_hazard,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        imem_ready,
    output logic        stall_IFP,
    output logic        stall_IFR,
    output logic        stall_IDR,
    output logic        stall_IDC,
    output logic        stall_EXB,
    output logic        stall_MEM,
    output logic        flush_IFR,
    output logic        flush_IDR,
    output logic        flush_IDC,
    output logic        flush_EXB,
    output logic        redirect_valid_IFP,
    output logic [63:0] redirect_target_IFP,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    typedef enum logic [1:0] {
        StRun          = 2'd0,
        StDmemWait     = 2'd1,
        StRedirectHold = 2'd2
    } state_e;

    state_e      r_state, w_state_d;
    logic [63:0] r_hold, w_hold_d;
    logic [31:0] r_wait, w_wait_d;
    logic        r_mem_prev;
    logic        r_timeout;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redirect_cnt;

    logic        w_mem_hold;
    logic [5:0]  w_stall;     // {IFP, IFR, IDR, IDC, EXB, MEM}
    logic [3:0]  w_flush;     // {IFR, IDR, IDC, EXB}
    logic        w_redir;
    logic [63:0] w_target;
    logic [5:0]  w_stall_o;
    logic        w_redir_o;
    logic        w_redir_taken;

    // A started data access keeps the pipe frozen until ready, even if dmem_req drops.
    assign w_mem_hold = (dmem_req & ~dmem_ready) | ((r_state == StDmemWait) & ~dmem_ready);

    always_comb begin
        w_stall   = 6'b000000;
        w_flush   = 4'b0000;
        w_redir   = 1'b0;
        w_target  = 64'd0;
        w_state_d = r_state;
        w_hold_d  = r_hold;
        if (w_mem_hold) begin
            w_stall = 6'b111111;
            // A pending redirect survives a memory stall; it is reissued once memory completes.
            if (r_state == StRun) begin
                w_state_d = StDmemWait;
            end
        end else if (r_state == StRedirectHold) begin
            w_stall[5] = 1'b1;
            w_flush[3] = 1'b1;
            w_redir    = 1'b1;
            w_target   = r_hold;
            if (branch_taken_EXB) begin
                w_flush  = 4'b1110;
                w_target = branch_target_EXB;
                w_hold_d = branch_target_EXB;
            end
            if (imem_ready) begin
                w_state_d = StRun;
            end
        end else begin
            w_state_d = StRun;
            if (branch_taken_EXB) begin
                w_flush  = 4'b1110;
                w_redir  = 1'b1;
                w_target = branch_target_EXB;
                if (!imem_ready) begin
                    w_hold_d  = branch_target_EXB;
                    w_state_d = StRedirectHold;
                end
            end else if (load_use_hazard) begin
                w_stall = 6'b111100;
                w_flush = 4'b0001;
            end else if (!imem_ready) begin
                w_stall[5] = 1'b1;
                w_flush[3] = 1'b1;
            end
        end
    end

    always_comb begin
        w_wait_d = r_wait;
        if (w_mem_hold) begin
            if (!r_mem_prev) begin
                w_wait_d = 32'd1;
            end else if (r_wait < TIMEOUT_CYCLES) begin
                w_wait_d = r_wait + 32'd1;
            end
        end
    end

    // Outputs are forced quiet while reset is held, independent of the inputs.
    assign w_stall_o     = w_stall & {6{rst_n}};
    assign w_redir_o     = w_redir & rst_n;
    assign w_redir_taken = w_redir_o & imem_ready;

    assign stall_IFP           = w_stall_o[5];
    assign stall_IFR           = w_stall_o[4];
    assign stall_IDR           = w_stall_o[3];
    assign stall_IDC           = w_stall_o[2];
    assign stall_EXB           = w_stall_o[1];
    assign stall_MEM           = w_stall_o[0];
    assign flush_IFR           = w_flush[3] & rst_n;
    assign flush_IDR           = w_flush[2] & rst_n;
    assign flush_IDC           = w_flush[1] & rst_n;
    assign flush_EXB           = w_flush[0] & rst_n;
    assign redirect_valid_IFP  = w_redir_o;
    assign redirect_target_IFP = w_target & {64{rst_n}};
    assign mem_timeout         = r_timeout;
    assign stall_cnt           = r_stall_cnt;
    assign redirect_cnt        = r_redirect_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StRun;
            r_hold         <= 64'd0;
            r_wait         <= 32'd0;
            r_mem_prev     <= 1'b0;
            r_timeout      <= 1'b0;
            r_stall_cnt    <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            r_state    <= w_state_d;
            r_hold     <= w_hold_d;
            r_wait     <= w_wait_d;
            r_mem_prev <= w_mem_hold;
            if (w_mem_hold && (w_wait_d >= TIMEOUT_CYCLES)) begin
                r_timeout <= 1'b1;
            end
            if ((|w_stall_o) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_redir_taken && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_stall_sched.sv
// Self-checking bench for stall_sched: per-cycle behavioural model compare plus directed
// scenarios with literal expectations.
module tb_stall_sched;

    localparam int unsigned TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br = 1'b0;
    logic [63:0] bt = 64'd0;
    logic        lu = 1'b0;
    logic        dreq = 1'b0;
    logic        drdy = 1'b1;
    logic        irdy = 1'b1;

    logic        s_ifp, s_ifr, s_idr, s_idc, s_exb, s_mem;
    logic        f_ifr, f_idr, f_idc, f_exb;
    logic        rv;
    logic [63:0] rt;
    logic        tmo;
    logic [31:0] scnt, rcnt;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state, phrased as outstanding work rather than FSM states.
    bit          m_waiting;
    bit          m_pending;
    logic [63:0] m_tgt;
    int unsigned m_run;
    bit          m_timeout;
    logic [31:0] m_scnt, m_rcnt;

    stall_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch_taken_EXB    (br),
        .branch_target_EXB   (bt),
        .load_use_hazard     (lu),
        .dmem_req            (dreq),
        .dmem_ready          (drdy),
        .imem_ready          (irdy),
        .stall_IFP           (s_ifp),
        .stall_IFR           (s_ifr),
        .stall_IDR           (s_idr),
        .stall_IDC           (s_idc),
        .stall_EXB           (s_exb),
        .stall_MEM           (s_mem),
        .flush_IFR           (f_ifr),
        .flush_IDR           (f_idr),
        .flush_IDC           (f_idc),
        .flush_EXB           (f_exb),
        .redirect_valid_IFP  (rv),
        .redirect_target_IFP (rt),
        .mem_timeout         (tmo),
        .stall_cnt           (scnt),
        .redirect_cnt        (rcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0]  e_st;
        logic [3:0]  e_fl;
        logic        e_rv;
        logic [63:0] e_rt;
        logic [139:0] act_v, exp_v;
        bit mem;
        e_st = '0; e_fl = '0; e_rv = 1'b0; e_rt = '0;
        if (!rst_n) begin
            m_waiting = 0; m_pending = 0; m_tgt = '0; m_run = 0;
            m_timeout = 0; m_scnt = '0; m_rcnt = '0;
        end else begin
            mem = (dreq && !drdy) || (m_waiting && !drdy);
            if (mem) begin
                e_st = 6'b111111;
            end else if (m_pending) begin
                e_st = 6'b100000; e_fl = 4'b1000; e_rv = 1'b1;
                e_rt = br ? bt : m_tgt;
                if (br) e_fl = 4'b1110;
            end else if (br) begin
                e_fl = 4'b1110; e_rv = 1'b1; e_rt = bt;
            end else if (lu) begin
                e_st = 6'b111100; e_fl = 4'b0001;
            end else if (!irdy) begin
                e_st = 6'b100000; e_fl = 4'b1000;
            end
        end
        exp_v = {e_st, e_fl, e_rv, e_rt, m_timeout, m_scnt, m_rcnt};
        act_v = {s_ifp, s_ifr, s_idr, s_idc, s_exb, s_mem, f_ifr, f_idr, f_idc, f_exb,
                 rv, rt, tmo, scnt, rcnt};
        n_vec++;
        if (act_v !== exp_v) begin
            n_miss++;
            $display("FAIL cycle@%0t: got %h expected %h", $time, act_v, exp_v);
        end
        if (rst_n) begin
            if (e_st != 0 && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (e_rv && irdy && m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 1;
            if (mem) begin
                m_run = m_run + 1;
                if (m_run >= TMO) m_timeout = 1;
            end else begin
                m_run = 0;
            end
            if (!mem) begin
                if (m_pending || br) begin
                    if (br) m_tgt = bt;
                    m_pending = !irdy;
                end
            end
            m_waiting = mem && !m_pending;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic b, input logic [63:0] t, input logic l, input logic rq,
                       input logic rd, input logic ir);
        br = b; bt = t; lu = l; dreq = rq; drdy = rd; irdy = ir;
    endtask

    task automatic idle();
        set(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with busy inputs: every control output must stay low.
        set(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        chk("rst_stall_mem", {63'd0, s_mem}, 64'd0);
        chk("rst_redir", {63'd0, rv}, 64'd0);
        chk("rst_target", rt, 64'd0);
        tick(); tick();
        idle();
        rst_n = 1'b1;
        tick(); tick();

        // Load-use bubble
        set(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("lu_stall_idc", {63'd0, s_idc}, 64'd1);
        chk("lu_flush_exb", {63'd0, f_exb}, 64'd1);
        chk("lu_stall_exb", {63'd0, s_exb}, 64'd0);
        tick(); idle(); #1;
        chk("lu_stall_cnt", {32'd0, scnt}, 64'd1);
        tick();

        // Branch accepted immediately
        set(1'b1, 64'h8000_0040, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("br_target", rt, 64'h8000_0040);
        chk("br_flush_idc", {63'd0, f_idc}, 64'd1);
        tick(); idle(); #1;
        chk("br_redirect_cnt", {32'd0, rcnt}, 64'd1);
        tick();

        // Branch wins over load-use
        set(1'b1, 64'h100, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("brlu_stall_idr", {63'd0, s_idr}, 64'd0);
        chk("brlu_flush_idr", {63'd0, f_idr}, 64'd1);
        tick();

        // Branch while fetch busy for 3 cycles
        set(1'b1, 64'h1234_5678_9ABC, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        #1;
        chk("hold_target", rt, 64'h1234_5678_9ABC);
        chk("hold_rcnt", {32'd0, rcnt}, 64'd2);
        tick();
        idle(); tick(); #1;
        chk("hold_rcnt_done", {32'd0, rcnt}, 64'd3);

        // Newer branch overwrites held target
        set(1'b1, 64'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set(1'b1, 64'hBBBB, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle(); #1;
        chk("newest_wins", rt, 64'hBBBB);
        tick();

        // Fetch wait alone, then memory stall while a redirect is pending
        set(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set(1'b1, 64'hC0C0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); tick();
        set(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle(); tick();

        // Memory stall with branch held throughout
        rst_pulse();
        set(1'b1, 64'h4000, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("mem_br_redir", {63'd0, rv}, 64'd0);
        repeat (5) tick();
        set(1'b1, 64'h4000, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("mem_ready_redir", {63'd0, rv}, 64'd1);
        tick(); idle(); #1;
        chk("mem_stall_cnt", {32'd0, scnt}, 64'd5);
        chk("mem_rcnt", {32'd0, rcnt}, 64'd1);
        tick();

        // Watchdog
        rst_pulse();
        set(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (i == 254) begin #1; chk("tmo_before", {63'd0, tmo}, 64'd0); end
            if (i == 255) begin #1; chk("tmo_at", {63'd0, tmo}, 64'd1); end
            tick();
        end
        set(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(); idle(); #1;
        chk("tmo_sticky", {63'd0, tmo}, 64'd1);
        chk("tmo_stall_cnt", {32'd0, scnt}, 64'd300);
        tick();

        // Reset in the middle of a memory wait abandons it
        set(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        rst_pulse();
        set(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("abandon_stall", {63'd0, s_mem}, 64'd0);
        chk("clr_tmo", {63'd0, tmo}, 64'd0);
        chk("clr_scnt", {32'd0, scnt}, 64'd0);
        chk("clr_rcnt", {32'd0, rcnt}, 64'd0);
        tick(); idle(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
